// File: rtl/bcd_lcd_writer.sv
// bcd_lcd_writer: turns a packed 4-digit BCD MM:SS value into a character-LCD
// write stream (one set-address command followed by "MM:SS") on a
// valid/ready byte interface. A frame is sent whenever the value differs from
// the last one sent, on a refresh request, and once after reset.
// Optional feature: define BCD_LCD_WRITER_BLANK_EN to show a leading zero in
// the tens-minutes position as a space.
module bcd_lcd_writer #(
  parameter logic [7:0] LINE_ADDR = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Digit,
  input  logic        refresh,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_rs,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, CMD, CHAR, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] snap_reg, snap_next;
  logic        pending_reg, pending_next;
  logic [2:0]  idx_reg, idx_next;
  logic        valid_reg, valid_next;
  logic        rs_reg, rs_next;
  logic [7:0]  data_reg, data_next;
  logic        xfer;

  // Character k (0..4) of the "MM:SS" text for a snapped value.
  function automatic logic [7:0] char_at(input logic [15:0] v, input logic [2:0] k);
    logic [3:0] n;
    logic [7:0] c;
    n = 4'h0;
    case (k)
      3'd0:    n = v[15:12];
      3'd1:    n = v[11:8];
      3'd3:    n = v[7:4];
      3'd4:    n = v[3:0];
      default: n = 4'h0;
    endcase
    // Nibbles outside 0..9 are not valid BCD; show them as '?'.
    c = (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    if (k == 3'd2) c = 8'h3A;
`ifdef BCD_LCD_WRITER_BLANK_EN
    if ((k == 3'd0) && (n == 4'h0)) c = 8'h20;
`else
`endif
    return c;
  endfunction

  assign xfer       = valid_reg & out_ready;
  assign out_valid  = valid_reg;
  assign out_rs     = rs_reg;
  assign out_data   = data_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);

  // State and output-byte registers; reset forces a frame right after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      snap_reg    <= 16'h0000;
      pending_reg <= 1'b1;
      idx_reg     <= 3'd0;
      valid_reg   <= 1'b0;
      rs_reg      <= 1'b0;
      data_reg    <= 8'h00;
    end else begin
      state_reg   <= state_next;
      snap_reg    <= snap_next;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      rs_reg      <= rs_next;
      data_reg    <= data_next;
    end
  end

  // Next-state logic: start detection, byte sequencing on each accepted transfer.
  always_comb begin
    state_next   = state_reg;
    snap_next    = snap_reg;
    pending_next = pending_reg | refresh;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    rs_next      = rs_reg;
    data_next    = data_reg;
    case (state_reg)
      IDLE: begin
        // A refresh coinciding with the start is absorbed into this frame.
        if (pending_reg || (Digit != snap_reg)) begin
          snap_next    = Digit;
          pending_next = 1'b0;
          state_next   = CMD;
          valid_next   = 1'b1;
          rs_next      = 1'b0;
          data_next    = LINE_ADDR;
        end
      end
      CMD: begin
        if (xfer) begin
          state_next = CHAR;
          idx_next   = 3'd0;
          rs_next    = 1'b1;
          data_next  = char_at(snap_reg, 3'd0);
        end
      end
      CHAR: begin
        if (xfer) begin
          if (idx_reg == 3'd4) begin
            state_next = DONE;
            valid_next = 1'b0;
          end else begin
            idx_next  = idx_reg + 3'd1;
            data_next = char_at(snap_reg, idx_reg + 3'd1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_lcd_writer.sv
// Self-checking bench for bcd_lcd_writer: scenario tasks plus randomized
// frames checked against a text-level model of the "MM:SS" frame.
module tb_bcd_lcd_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Digit;
  logic        refresh;
  logic        out_valid;
  logic        out_ready;
  logic        out_rs;
  logic [7:0]  out_data;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // Results of the most recent capture.
  logic [8:0] got [0:7];
  int got_n, done_seen, done_x, unstable, first_x, last_x;
  bit timed_out;

  always #5 clk = ~clk;

  bcd_lcd_writer #(.LINE_ADDR(8'h80)) dut (
    .clk(clk), .rst(rst), .Digit(Digit), .refresh(refresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs(out_rs),
    .out_data(out_data), .busy(busy), .frame_done(frame_done)
  );

  // Expected k-th transfer {rs,data} of the frame for value v.
  function automatic logic [8:0] model_byte(input logic [15:0] v, input int k);
    logic [3:0] n;
    logic [7:0] c;
    if (k == 0) return {1'b0, 8'h80};
    if (k == 3) return {1'b1, 8'h3A};
    case (k)
      1: n = v[15:12];
      2: n = v[11:8];
      4: n = v[7:4];
      default: n = v[3:0];
    endcase
    c = (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
`ifdef BCD_LCD_WRITER_BLANK_EN
    if (k == 1 && n == 4'h0) c = 8'h20;
`endif
    return {1'b1, c};
  endfunction

  // Drives out_ready per mode (0 high, 1 toggling, 2 random) and records
  // transfers until 6 bytes and a frame_done are seen. Optionally changes
  // Digit (and pulses refresh) once chg_at bytes have been accepted.
  task automatic capture(input int mode, input int chg_at, input logic [15:0] chg_val,
                         input bit chg_refresh);
    bit held;
    bit changed;
    logic [8:0] prev;
    got_n = 0; done_seen = 0; done_x = -1; unstable = 0; first_x = -1; last_x = -1;
    timed_out = 1'b1; held = 1'b0; changed = 1'b0; prev = 9'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      refresh = 1'b0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (frame_done) begin
        done_seen++;
        done_x = cyc;
      end
      if (held && (!out_valid || {out_rs, out_data} !== prev)) unstable++;
      if (out_valid && out_ready) begin
        if (got_n < 8) got[got_n] = {out_rs, out_data};
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        got_n++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        prev = {out_rs, out_data};
      end else begin
        held = 1'b0;
      end
      if (!changed && chg_at >= 0 && got_n == chg_at) begin
        Digit = chg_val;
        refresh = chg_refresh;
        changed = 1'b1;
      end
      if (got_n >= 6 && done_seen > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit saw;
    rst = 1'b1; refresh = 1'b0; out_ready = 1'b0; Digit = 16'h1234;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_rs, out_data, frame_done} !== 11'h0)
      $display("FAIL reset_outputs got=%h want=000", {out_valid, out_rs, out_data, frame_done});
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    if (busy !== 1'b0 || {out_valid, out_rs, out_data, frame_done} !== 11'h0) failures++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_rs, out_data} !== {1'b1, 1'b0, 8'h80}) begin
      failures++;
      $display("FAIL start_latency got=%h want=280", {out_valid, out_rs, out_data});
    end
    capture(0, -1, 16'h0, 1'b0);
    checks++;
    if (timed_out || got_n != 6 || done_seen != 1) begin
      failures++;
      $display("FAIL reset_frame_count got=%0d/%0d/%0d want=0/6/1", timed_out, got_n, done_seen);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== model_byte(16'h1234, k)) begin
        failures++;
        $display("FAIL reset_frame_byte%0d got=%h want=%h", k, got[k], model_byte(16'h1234, k));
      end
    end
    checks++;
    if (last_x - first_x != 5 || done_x != last_x + 1) begin
      failures++;
      $display("FAIL full_rate_timing got=%0d,%0d want=5,%0d", last_x - first_x, done_x, last_x + 1);
    end
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL reset_idle_after got=activity want=idle");
    end
  endtask

  task automatic test_toggle_ready;
    bit saw;
    @(negedge clk);
    refresh = 1'b1; out_ready = 1'b0;
    capture(1, -1, 16'h0, 1'b0);
    checks++;
    if (timed_out || got_n != 6 || unstable != 0) begin
      failures++;
      $display("FAIL toggle_frame got=n%0d unstable%0d want=n6 unstable0", got_n, unstable);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== model_byte(16'h1234, k)) begin
        failures++;
        $display("FAIL toggle_byte%0d got=%h want=%h", k, got[k], model_byte(16'h1234, k));
      end
    end
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL refresh_single_frame got=extra want=none");
    end
  endtask

  task automatic test_mid_change;
    @(negedge clk);
    Digit = 16'h0001;
    capture(0, 2, 16'h0002, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (timed_out || got[k] !== model_byte(16'h0001, k)) begin
        failures++;
        $display("FAIL mid_first_byte%0d got=%h want=%h", k, got[k], model_byte(16'h0001, k));
      end
    end
    capture(0, -1, 16'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (timed_out || got[k] !== model_byte(16'h0002, k)) begin
        failures++;
        $display("FAIL mid_second_byte%0d got=%h want=%h", k, got[k], model_byte(16'h0002, k));
      end
    end
    checks++;
    if (first_x != 1) begin
      failures++;
      $display("FAIL mid_second_start got=%0d want=1", first_x);
    end
  endtask

  task automatic test_back_to_back;
    bit saw;
    @(negedge clk);
    Digit = 16'h2345;
    capture(2, 3, 16'h2345, 1'b1);
    capture(2, -1, 16'h0, 1'b0);
    checks++;
    if (timed_out || got_n != 6) begin
      failures++;
      $display("FAIL b2b_extra_frame got=n%0d timeout%0d want=n6 timeout0", got_n, timed_out);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== model_byte(16'h2345, k)) begin
        failures++;
        $display("FAIL b2b_byte%0d got=%h want=%h", k, got[k], model_byte(16'h2345, k));
      end
    end
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL b2b_only_one_extra got=extra want=none");
    end
  endtask

  task automatic test_bad_bcd;
    @(negedge clk);
    Digit = 16'h5A59;
    capture(0, -1, 16'h0, 1'b0);
    checks++;
    if (timed_out || got[2] !== {1'b1, 8'h3F}) begin
      failures++;
      $display("FAIL bad_bcd_qmark got=%h want=13f", got[2]);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== model_byte(16'h5A59, k)) begin
        failures++;
        $display("FAIL bad_bcd_byte%0d got=%h want=%h", k, got[k], model_byte(16'h5A59, k));
      end
    end
  endtask

  task automatic test_blank;
    logic [8:0] want;
`ifdef BCD_LCD_WRITER_BLANK_EN
    want = {1'b1, 8'h20};
`else
    want = {1'b1, 8'h30};
`endif
    @(negedge clk);
    Digit = 16'h0959;
    capture(0, -1, 16'h0, 1'b0);
    checks++;
    if (timed_out || got[1] !== want) begin
      failures++;
      $display("FAIL blank_first_char got=%h want=%h", got[1], want);
    end
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (got[k] !== model_byte(16'h0959, k)) begin
        failures++;
        $display("FAIL blank_byte%0d got=%h want=%h", k, got[k], model_byte(16'h0959, k));
      end
    end
  endtask

  task automatic test_rst_mid;
    int cnt;
    bit saw;
    @(negedge clk);
    Digit = 16'h0777; out_ready = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 50 && cnt < 3; cyc++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) cnt++;
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_rs, out_data} !== {2'b11, 8'h3A}) begin
      failures++;
      $display("FAIL rst_mid_4th_byte got=%h want=33a", {out_valid, out_rs, out_data});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, out_data} !== 10'h0) begin
      failures++;
      $display("FAIL rst_mid_abandon got=%h want=000", {out_valid, busy, out_data});
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_rs, out_data} !== {1'b1, 1'b0, 8'h80}) begin
      failures++;
      $display("FAIL rst_mid_restart got=%h want=280", {out_valid, out_rs, out_data});
    end
    capture(0, -1, 16'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (timed_out || got[k] !== model_byte(16'h0777, k)) begin
        failures++;
        $display("FAIL rst_mid_byte%0d got=%h want=%h", k, got[k], model_byte(16'h0777, k));
      end
    end
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL rst_mid_idle got=extra want=none");
    end
  endtask

  task automatic test_random;
    logic [15:0] v;
    int bad;
    for (int t = 0; t < 20; t++) begin
      v = 16'($urandom);
      if (v == Digit) v = v ^ 16'h0001;
      @(negedge clk);
      Digit = v;
      capture(2, -1, 16'h0, 1'b0);
      bad = 0;
      for (int k = 0; k < 6; k++)
        if (got[k] !== model_byte(v, k)) bad++;
      checks++;
      if (timed_out || got_n != 6 || unstable != 0 || bad != 0) begin
        failures++;
        $display("FAIL random_frame v=%h got=%h %h %h %h %h %h n=%0d unstable=%0d want=%h %h %h %h %h %h",
                 v, got[0], got[1], got[2], got[3], got[4], got[5], got_n, unstable,
                 model_byte(v, 0), model_byte(v, 1), model_byte(v, 2),
                 model_byte(v, 3), model_byte(v, 4), model_byte(v, 5));
      end else begin
        $display("frame v=%h bytes=%h %h %h %h %h %h ok", v, got[0], got[1], got[2], got[3], got[4], got[5]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_toggle_ready();
    test_mid_change();
    test_back_to_back();
    test_bad_bcd();
    test_blank();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
